// File: rtl/alu_rr_sched.sv
// Round-robin front end that lets two requesters share one external signed ALU.
// One op is in flight at a time: IDLE accepts, EXEC holds operands, RESP returns the result.
module alu_rr_sched #(
    parameter int unsigned W           = 5,
    parameter int unsigned FW          = 3,
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic [1:0]      req_valid_i,
    output logic [1:0]      req_ready_o,
    input  logic [2*FW-1:0] req_func_i,
    input  logic [2*W-1:0]  req_a_i,
    input  logic [2*W-1:0]  req_b_i,

    output logic [W-1:0]    alu_a_o,
    output logic [W-1:0]    alu_b_o,
    output logic [FW-1:0]   alu_func_o,
    input  logic [W-1:0]    alu_out_i,
    input  logic            alu_zero_i,
    input  logic            alu_ovf_i,
    input  logic            alu_cout_i,

    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            rsp_id_o,
    output logic [W-1:0]    rsp_data_o,
    output logic            rsp_zero_o,
    output logic            rsp_ovf_o,
    output logic            rsp_cout_o,

    output logic            busy_o
);

    if (EXEC_CYCLES < 1) begin : g_bad_exec_cycles
        $error("alu_rr_sched: EXEC_CYCLES must be at least 1");
    end

    localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [FW-1:0]   alu_func_q, alu_func_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic            rsp_zero_q, rsp_zero_d;
    logic            rsp_ovf_q, rsp_ovf_d;
    logic            rsp_cout_q, rsp_cout_d;

    logic            grant;
    logic            any_valid;
    logic [1:0]      ready_raw;

    // Single requester wins outright; on contention the one not served last goes next.
    always_comb begin
        grant     = 1'b0;
        any_valid = |req_valid_i;
        case (req_valid_i)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        ready_raw = 2'b00;
        if (state_q == StIdle && any_valid) begin
            ready_raw = grant ? 2'b10 : 2'b01;
        end
    end

    assign req_ready_o = ready_raw & {2{rst_n}};

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_func_d   = alu_func_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_cout_d   = rsp_cout_q;

        case (state_q)
            StIdle: begin
                if (any_valid) begin
                    alu_a_d      = grant ? req_a_i[2*W-1:W]     : req_a_i[W-1:0];
                    alu_b_d      = grant ? req_b_i[2*W-1:W]     : req_b_i[W-1:0];
                    alu_func_d   = grant ? req_func_i[2*FW-1:FW] : req_func_i[FW-1:0];
                    rsp_id_d     = grant;
                    last_grant_d = grant;
                    cnt_d        = CntW'(EXEC_CYCLES - 1);
                    state_d      = StExec;
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_data_d  = alu_out_i;
                    rsp_zero_d  = alu_zero_i;
                    rsp_ovf_d   = alu_ovf_i;
                    rsp_cout_d  = alu_cout_i;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_func_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_func_q   <= alu_func_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_func_o  = alu_func_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_zero_o  = rsp_zero_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: two instances (1 and 3 exec cycles) each driving a behavioural ALU.
// Directed vector table, contention/backpressure/reset sequences, then randomized ops.
module tb_alu_rr_sched;

    localparam int W  = 5;
    localparam int FW = 3;

    logic clk;
    logic rst_n;

    logic [1:0]      req_valid1, req_ready1;
    logic [2*FW-1:0] req_func1;
    logic [2*W-1:0]  req_a1, req_b1;
    logic [W-1:0]    alu_a1, alu_b1, alu_out1;
    logic [FW-1:0]   alu_func1;
    logic            alu_zero1, alu_ovf1, alu_cout1;
    logic            rsp_valid1, rsp_ready1, rsp_id1, rsp_zero1, rsp_ovf1, rsp_cout1, busy1;
    logic [W-1:0]    rsp_data1;

    logic [1:0]      req_valid3, req_ready3;
    logic [2*FW-1:0] req_func3;
    logic [2*W-1:0]  req_a3, req_b3;
    logic [W-1:0]    alu_a3, alu_b3, alu_out3;
    logic [FW-1:0]   alu_func3;
    logic            alu_zero3, alu_ovf3, alu_cout3;
    logic            rsp_valid3, rsp_ready3, rsp_id3, rsp_zero3, rsp_ovf3, rsp_cout3, busy3;
    logic [W-1:0]    rsp_data3;

    int tests;
    int fails;
    int cyc;

    alu_rr_sched #(.W(W), .FW(FW), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_func_i(req_func1),
        .req_a_i(req_a1), .req_b_i(req_b1),
        .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_func_o(alu_func1),
        .alu_out_i(alu_out1), .alu_zero_i(alu_zero1), .alu_ovf_i(alu_ovf1), .alu_cout_i(alu_cout1),
        .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready1), .rsp_id_o(rsp_id1),
        .rsp_data_o(rsp_data1), .rsp_zero_o(rsp_zero1), .rsp_ovf_o(rsp_ovf1),
        .rsp_cout_o(rsp_cout1), .busy_o(busy1)
    );

    alu_rr_sched #(.W(W), .FW(FW), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_func_i(req_func3),
        .req_a_i(req_a3), .req_b_i(req_b3),
        .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_func_o(alu_func3),
        .alu_out_i(alu_out3), .alu_zero_i(alu_zero3), .alu_ovf_i(alu_ovf3), .alu_cout_i(alu_cout3),
        .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready3), .rsp_id_o(rsp_id3),
        .rsp_data_o(rsp_data3), .rsp_zero_o(rsp_zero3), .rsp_ovf_o(rsp_ovf3),
        .rsp_cout_o(rsp_cout3), .busy_o(busy3)
    );

    // Behavioural ALU: add, sub, and, or, xor, nor, signed less-than, equal. Returns {out,z,v,c}.
    function automatic logic [7:0] alu_model(input logic [2:0] f, input logic [4:0] a,
                                             input logic [4:0] b);
        logic [5:0] s;
        logic [4:0] o;
        logic       ov, co;
        s = '0; o = '0; ov = 1'b0; co = 1'b0;
        case (f)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b}; o = s[4:0]; co = s[5];
                ov = (a[4] == b[4]) && (o[4] != a[4]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 6'd1; o = s[4:0]; co = s[5];
                ov = (a[4] != b[4]) && (o[4] != a[4]);
            end
            3'b010:  o = a & b;
            3'b011:  o = a | b;
            3'b100:  o = a ^ b;
            3'b101:  o = ~(a | b);
            3'b110:  o = {4'b0, ($signed(a) < $signed(b))};
            default: o = {4'b0, (a == b)};
        endcase
        return {o, (o == 5'd0), ov, co};
    endfunction

    always_comb {alu_out1, alu_zero1, alu_ovf1, alu_cout1} = alu_model(alu_func1, alu_a1, alu_b1);
    always_comb {alu_out3, alu_zero3, alu_ovf3, alu_cout3} = alu_model(alu_func3, alu_a3, alu_b3);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Wait after a handshake edge for rsp_valid on the 1-cycle instance; n = negedges waited.
    task automatic wait_rsp1(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid1 && n < 20);
    endtask

    // Issue one op on requester id of the 1-cycle instance, scramble inputs after the handshake.
    task automatic do_op1(input string tag, input logic id, input logic [2:0] f,
                          input logic [4:0] a, input logic [4:0] b, output int lat);
        int gi;
        gi = int'(id);
        @(negedge clk);
        req_func1 = 6'($urandom);
        req_a1    = 10'($urandom);
        req_b1    = 10'($urandom);
        req_func1[gi*FW +: FW] = f;
        req_a1[gi*W +: W]      = a;
        req_b1[gi*W +: W]      = b;
        req_valid1             = id ? 2'b10 : 2'b01;
        #1;
        check({tag, "_ready"}, 32'(req_ready1), id ? 32'h2 : 32'h1);
        @(posedge clk);
        #1;
        req_valid1 = 2'b00;
        req_func1  = 6'($urandom);
        req_a1     = 10'($urandom);
        req_b1     = 10'($urandom);
        wait_rsp1(lat);
    endtask

    typedef struct {
        logic       id;
        logic [2:0] func;
        logic [4:0] a;
        logic [4:0] b;
        logic [4:0] data;
        logic       zero;
        logic       ovf;
        logic       cout;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int         lat;
        int         n;
        int         guard;
        int         gi;
        logic       lastg;
        logic       g;
        logic [1:0] v;
        logic [8:0] exp_rsp;
        logic [8:0] snap;
        logic       ids[6];
        logic [4:0] dats[6];
        int         tstamp[6];

        vecs[0]  = '{1'b0, 3'b000, 5'b00011, 5'b00010, 5'b00101, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 3'b000, 5'b01111, 5'b00001, 5'b10000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 3'b001, 5'b00101, 5'b00101, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 3'b111, 5'b00101, 5'b00101, 5'b00001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'b010, 5'b01100, 5'b01010, 5'b01000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 3'b011, 5'b01100, 5'b01010, 5'b01110, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'b100, 5'b01100, 5'b01010, 5'b00110, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b101, 5'b01100, 5'b01010, 5'b10001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 3'b110, 5'b11111, 5'b00001, 5'b00001, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b001, 5'b10000, 5'b00001, 5'b01111, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 3'b000, 5'b11111, 5'b00001, 5'b00000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'b110, 5'b00001, 5'b11111, 5'b00000, 1'b1, 1'b0, 1'b0};

        tests = 0; fails = 0; cyc = 0;
        rst_n = 1'b0;
        req_valid1 = 2'b11; req_func1 = '0; req_a1 = '0; req_b1 = '0; rsp_ready1 = 1'b1;
        req_valid3 = 2'b11; req_func3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state, with requests pending
        check("rst_ready1", 32'(req_ready1), 32'h0);
        check("rst_ready3", 32'(req_ready3), 32'h0);
        check("rst_outs1", {rsp_valid1, busy1, rsp_id1, rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1},
              32'h0);
        check("rst_alu1", {alu_a1, alu_b1, alu_func1}, 32'h0);
        check("rst_outs3", {rsp_valid3, busy3, alu_a3, alu_b3, alu_func3}, 32'h0);
        req_valid1 = 2'b00;
        req_valid3 = 2'b00;
        rst_n = 1'b1;

        // Directed vector table on the single-cycle instance
        for (int i = 0; i < 12; i++) begin
            do_op1($sformatf("vec%0d", i), vecs[i].id, vecs[i].func, vecs[i].a, vecs[i].b, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_id", i), 32'(rsp_id1), 32'(vecs[i].id));
            check($sformatf("vec%0d_result", i), {rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1},
                  {vecs[i].data, vecs[i].zero, vecs[i].ovf, vecs[i].cout});
        end

        // Contention: both valid continuously, expect strict alternation starting at r0
        do_reset();
        @(negedge clk);
        req_func1 = 6'b000_000;
        req_a1 = {5'd2, 5'd1};
        req_b1 = {5'd2, 5'd1};
        req_valid1 = 2'b11;
        n = 0; guard = 0;
        while (n < 6 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (rsp_valid1) begin
                ids[n] = rsp_id1; dats[n] = rsp_data1; tstamp[n] = cyc;
                n++;
            end
        end
        req_valid1 = 2'b00;
        check("contend_count", 32'(n), 32'd6);
        for (int i = 0; i < n; i++) begin
            check($sformatf("contend%0d_id", i), 32'(ids[i]), 32'(i % 2));
            check($sformatf("contend%0d_data", i), 32'(dats[i]), (i % 2 == 1) ? 32'd4 : 32'd2);
            if (i > 0) check($sformatf("contend%0d_period", i), 32'(tstamp[i] - tstamp[i-1]),
                             32'd3);
        end

        // Backpressure: response held while consumer stalls; no new acceptance
        @(negedge clk);
        rsp_ready1 = 1'b0;
        do_op1("bp", 1'b0, 3'b000, 5'b00110, 5'b00001, lat);
        check("bp_result", {rsp_valid1, rsp_id1, rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1},
              {1'b1, 1'b0, 5'b00111, 3'b000});
        snap = {rsp_id1, rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1};
        req_valid1 = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp%0d_hold", i), {rsp_valid1, busy1, req_ready1,
                  rsp_id1, rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1}, {1'b1, 1'b1, 2'b00, snap});
        end
        req_valid1 = 2'b00;
        rsp_ready1 = 1'b1;
        @(negedge clk);
        check("bp_release", {rsp_valid1, busy1}, 32'h0);

        // Reset in the middle of RESP clears everything without a clock edge
        rsp_ready1 = 1'b0;
        do_op1("midrst", 1'b1, 3'b011, 5'b01010, 5'b00101, lat);
        check("midrst_pre", {rsp_valid1, busy1, alu_a1}, {1'b1, 1'b1, 5'b01010});
        req_valid1 = 2'b01;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {rsp_valid1, busy1, req_ready1}, 32'h0);
        check("midrst_alu", {alu_a1, alu_b1, alu_func1}, 32'h0);
        check("midrst_rsp", {rsp_id1, rsp_data1, rsp_zero1, rsp_ovf1, rsp_cout1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid1 = 2'b00;
        rsp_ready1 = 1'b1;

        // Randomized ops on the 3-cycle instance against the ALU model and grant tracker
        do_reset();
        lastg = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            req_func3 = 6'($urandom);
            req_a3    = 10'($urandom);
            req_b3    = 10'($urandom);
            case ($urandom_range(0, 2))
                0:       begin v = 2'b01; g = 1'b0;   end
                1:       begin v = 2'b10; g = 1'b1;   end
                default: begin v = 2'b11; g = ~lastg; end
            endcase
            gi = int'(g);
            exp_rsp = {g, alu_model(req_func3[gi*FW +: FW], req_a3[gi*W +: W], req_b3[gi*W +: W])};
            req_valid3 = v;
            #1;
            check($sformatf("rnd%0d_ready", k), 32'(req_ready3), g ? 32'h2 : 32'h1);
            @(posedge clk);
            #1;
            lastg = g;
            req_valid3 = 2'b00;
            req_func3  = 6'($urandom);
            req_a3     = 10'($urandom);
            req_b3     = 10'($urandom);
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!rsp_valid3 && lat < 20);
            check($sformatf("rnd%0d_latency", k), 32'(lat), 32'd4);
            check($sformatf("rnd%0d_rsp", k),
                  {rsp_id3, rsp_data3, rsp_zero3, rsp_ovf3, rsp_cout3}, 32'(exp_rsp));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
